// File: rtl/caliptra_prim_mubi_pkg.sv
// Multi-bit boolean (mubi) encodings and test helpers.
// Only the 4-bit flavour is provided: MuBi4True / MuBi4False are the sole
// legal values, and every other code counts as neither true nor false.
package caliptra_prim_mubi_pkg;

  typedef enum logic [3:0] {
    MuBi4True  = 4'h6,
    MuBi4False = 4'h9
  } mubi4_t;

  // True only for the exact MuBi4True code; corrupted values are not true.
  function automatic logic mubi4_test_true_strict(mubi4_t val);
    return (val == MuBi4True);
  endfunction

  // True for any code that is neither MuBi4True nor MuBi4False.
  function automatic logic mubi4_test_invalid(mubi4_t val);
    return (val != MuBi4True) && (val != MuBi4False);
  endfunction

endpackage

// File: rtl/entropy_src_enable_seq_pkg.sv
// Shared definitions for the entropy_src enable sequencer: the sparse FSM
// state encoding and the counter width helper.
package entropy_src_enable_seq_pkg;

  localparam int StateW = 6;

  // Every pair of legal codes differs in at least 3 bits, so one or two
  // flipped bits always land on an illegal code that the FSM can detect.
  typedef enum logic [StateW-1:0] {
    Idle    = 6'b000000,
    En      = 6'b000111,
    Drain   = 6'b011001,
    ShaWait = 6'b101010,
    Hold    = 6'b110100
  } state_e;

  // Width of a counter that must represent 0..max_val inclusive.
  function automatic int cnt_width(int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/entropy_src_enable_sequencer.sv
// Enable sequencer for entropy_src_core.
// Turns the raw module enable into a qualified enable that
//   - stays high for a bounded drain period after enable falls, while any
//     non-bypassed pipeline FIFO still holds data,
//   - then optionally waits (enable low, still busy) for an outstanding SHA3
//     operation to report done, with a timeout,
//   - and always spends one Hold cycle low before re-enabling.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   enable_i             raw module enable
//   fifo_not_empty_i     per-FIFO not-empty flags (NumFifos bits)
//   bypass_mode_i        when set, FIFOs selected by BypassMask are ignored
//   cs_aes_halt_req_i    SHA3 operation outstanding
//   sha3_done_i          SHA3 done (mubi4)
//   enable_o             qualified enable (En, Drain)
//   busy_o               disable sequence in progress (Drain, ShaWait, Hold)
//   sha_timeout_err_o    one-cycle pulse when the SHA wait times out
//   fsm_err_o            sticky illegal-state flag
module entropy_src_enable_sequencer
  import caliptra_prim_mubi_pkg::*;
  import entropy_src_enable_seq_pkg::*;
#(
  parameter int                  NumFifos    = 4,
  parameter logic [NumFifos-1:0] BypassMask  = 4'b0011,
  parameter int                  MaxFifoWait = 4,
  parameter int                  ShaTimeout  = 256
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                enable_i,
  input  logic [NumFifos-1:0] fifo_not_empty_i,
  input  logic                bypass_mode_i,
  input  logic                cs_aes_halt_req_i,
  input  mubi4_t              sha3_done_i,
  output logic                enable_o,
  output logic                busy_o,
  output logic                sha_timeout_err_o,
  output logic                fsm_err_o
);

  localparam int DrainCntW = cnt_width(MaxFifoWait);
  localparam int ShaCntW   = cnt_width(ShaTimeout);

  if (MaxFifoWait < 1 || MaxFifoWait > 15) begin : gen_bad_max_fifo_wait
    $error("MaxFifoWait must be in 1..15");
  end
  if (ShaTimeout < 2) begin : gen_bad_sha_timeout
    $error("ShaTimeout must be at least 2");
  end
  if (NumFifos < 1) begin : gen_bad_num_fifos
    $error("NumFifos must be at least 1");
  end

  state_e                 state_q, state_d;
  logic [DrainCntW-1:0]   drain_cnt_q, drain_cnt_d;
  logic [ShaCntW-1:0]     sha_cnt_q, sha_cnt_d;
  logic                   sha_pending_q, sha_pending_d;
  mubi4_t                 sha3_done_q;
  logic                   sha_timeout_err_q, timeout_hit;
  logic                   fsm_err_q, fsm_err_d;
  logic                   fifo_active;
  logic                   pending_set, pending_clr, pending_nxt;

  assign fifo_active = |(fifo_not_empty_i & ~(bypass_mode_i ? BypassMask : '0));

  // Set wins over the done-clear; the timeout clear is applied on top.
  // pending_nxt is what the flop will hold next cycle ignoring a timeout,
  // which lets ShaWait leave one cycle after sha3_done_q reads true.
  assign pending_set   = cs_aes_halt_req_i & ~enable_i;
  assign pending_clr   = mubi4_test_true_strict(sha3_done_q);
  assign pending_nxt   = pending_set | (sha_pending_q & ~pending_clr);
  assign sha_pending_d = pending_set | (sha_pending_q & ~pending_clr & ~timeout_hit);

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    sha_cnt_d   = sha_cnt_q;
    timeout_hit = 1'b0;
    fsm_err_d   = fsm_err_q;
    case (state_q)
      Idle: begin
        if (enable_i) state_d = En;
      end
      En: begin
        if (!enable_i) begin
          state_d     = Drain;
          drain_cnt_d = DrainCntW'(MaxFifoWait - 1);
        end
      end
      Drain: begin
        // enable_i is deliberately ignored here; re-enable goes via Hold.
        if (!fifo_active || drain_cnt_q == '0) begin
          sha_cnt_d = '0;
          state_d   = (sha_pending_q || pending_set) ? ShaWait : Hold;
        end else begin
          drain_cnt_d = drain_cnt_q - DrainCntW'(1);
        end
      end
      ShaWait: begin
        if (!pending_nxt) begin
          state_d = Hold;
        end else if (sha_cnt_q == ShaCntW'(ShaTimeout - 1)) begin
          state_d     = Hold;
          timeout_hit = 1'b1;
        end else begin
          sha_cnt_d = sha_cnt_q + ShaCntW'(1);
        end
      end
      Hold: begin
        state_d = enable_i ? En : Idle;
      end
      default: begin
        state_d   = Idle;
        fsm_err_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q           <= Idle;
      drain_cnt_q       <= '0;
      sha_cnt_q         <= '0;
      sha_pending_q     <= 1'b0;
      sha3_done_q       <= MuBi4False;
      sha_timeout_err_q <= 1'b0;
      fsm_err_q         <= 1'b0;
    end else begin
      state_q           <= state_d;
      drain_cnt_q       <= drain_cnt_d;
      sha_cnt_q         <= sha_cnt_d;
      sha_pending_q     <= sha_pending_d;
      sha3_done_q       <= sha3_done_i;
      sha_timeout_err_q <= timeout_hit;
      fsm_err_q         <= fsm_err_d;
    end
  end

  // Outputs come straight from registered state so they are glitch-free.
  assign enable_o          = (state_q == En) || (state_q == Drain);
  assign busy_o            = (state_q == Drain) || (state_q == ShaWait) || (state_q == Hold);
  assign sha_timeout_err_o = sha_timeout_err_q;
  assign fsm_err_o         = fsm_err_q;

endmodule

// File: tb/tb_entropy_src_enable_sequencer.sv
// Self-checking bench for entropy_src_enable_sequencer.
module tb_entropy_src_enable_sequencer;
  import caliptra_prim_mubi_pkg::*;
  import entropy_src_enable_seq_pkg::*;

  localparam logic [3:0] T = 4'h6;
  localparam logic [3:0] F = 4'h9;
  localparam logic [3:0] Z = 4'h0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] fifo = 4'b0000;
  logic       bypass = 1'b0;
  logic       halt = 1'b0;
  mubi4_t     done = MuBi4False;
  logic       enable_o, busy_o, sha_timeout_err_o, fsm_err_o;

  always #5 clk = ~clk;

  entropy_src_enable_sequencer #(
    .NumFifos   (4),
    .BypassMask (4'b0011),
    .MaxFifoWait(4),
    .ShaTimeout (8)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .enable_i         (enable),
    .fifo_not_empty_i (fifo),
    .bypass_mode_i    (bypass),
    .cs_aes_halt_req_i(halt),
    .sha3_done_i      (done),
    .enable_o         (enable_o),
    .busy_o           (busy_o),
    .sha_timeout_err_o(sha_timeout_err_o),
    .fsm_err_o        (fsm_err_o)
  );

  typedef struct {
    logic       en;
    logic [3:0] fifo;
    logic       byp;
    logic       halt;
    logic [3:0] done;
    logic       xen;
    logic       xbusy;
    logic       xterr;
  } vec_t;

  typedef struct packed {
    logic en;
    logic busy;
    logic terr;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic en, logic [3:0] f, logic byp, logic h, logic [3:0] d,
                              logic xen, logic xbusy, logic xterr);
    vec_t v;
    v.en = en; v.fifo = f; v.byp = byp; v.halt = h; v.done = d;
    v.xen = xen; v.xbusy = xbusy; v.xterr = xterr;
    return v;
  endfunction

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %b want %b", name, act, req);
    end
  endtask

  // Drive one row at a negedge, queue its expected outputs, and compare
  // them at the following negedge (after the sampling posedge).
  task automatic step(input vec_t v, input string name);
    exp_t e;
    enable = v.en; fifo = v.fifo; bypass = v.byp; halt = v.halt;
    done = mubi4_t'(v.done);
    exp_q.push_back('{v.xen, v.xbusy, v.xterr});
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if ({enable_o, busy_o, sha_timeout_err_o, fsm_err_o} !== {e.en, e.busy, e.terr, 1'b0}) begin
      errors++;
      $display("FAIL %s en/busy/terr/ferr got %b%b%b%b want %b%b%b0", name,
               enable_o, busy_o, sha_timeout_err_o, fsm_err_o, e.en, e.busy, e.terr);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_enable", enable_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_terr", sha_timeout_err_o, 1'b0);
    chk("rst_ferr", fsm_err_o, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_enable", enable_o, 1'b0);

    // Rise/fall with empty FIFOs
    vecs.push_back(mk(0, 0, 0, 0, F, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, F, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, F, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, F, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, F, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, F, 0, 0, 0));
    // Single-cycle enable pulse
    vecs.push_back(mk(1, 0, 0, 0, F, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, F, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, F, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, F, 0, 0, 0));
    // Stuck FIFO 3: Drain lasts exactly MaxFifoWait=4 cycles
    vecs.push_back(mk(1, 0, 0, 0, F, 1, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 4'b1000, 0, 0, F, 1, 1, 0));
    vecs.push_back(mk(0, 4'b1000, 0, 0, F, 0, 1, 0));
    vecs.push_back(mk(0, 4'b1000, 0, 0, F, 0, 0, 0));
    // FIFO 0 counts without bypass, is masked with bypass
    vecs.push_back(mk(1, 0, 0, 0, F, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0001, 1, 0, F, 1, 1, 0));
    vecs.push_back(mk(0, 4'b0001, 0, 0, F, 1, 1, 0));
    vecs.push_back(mk(0, 4'b0001, 1, 0, F, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, F, 0, 0, 0));
    // FIFO 2 is not in the bypass mask
    vecs.push_back(mk(1, 0, 0, 0, F, 1, 0, 0));
    vecs.push_back(mk(0, 4'b0100, 1, 0, F, 1, 1, 0));
    vecs.push_back(mk(0, 4'b0100, 1, 0, F, 1, 1, 0));
    vecs.push_back(mk(0, 0, 1, 0, F, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, F, 0, 0, 0));
    // Re-enable during Drain ignored; goes through Hold then En
    vecs.push_back(mk(1, 0, 0, 0, F, 1, 0, 0));
    vecs.push_back(mk(0, 4'b1000, 0, 0, F, 1, 1, 0));
    vecs.push_back(mk(1, 4'b1000, 0, 0, F, 1, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, F, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, F, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, F, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, F, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, F, 0, 0, 0));
    // SHA wait ended by done; enable held high -> En right after Hold
    vecs.push_back(mk(1, 0, 0, 0, F, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, F, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, F, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, F, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, F, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, F, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, T, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, F, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, F, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, F, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, F, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, F, 0, 0, 0));
    // SHA timeout: 8 ShaWait cycles, single pulse with Hold
    vecs.push_back(mk(1, 0, 0, 0, F, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, F, 1, 1, 0));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 0, 0, 0, F, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, F, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, F, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, F, 0, 0, 0));
    // Pending was cleared by the timeout: next disable skips ShaWait
    vecs.push_back(mk(1, 0, 0, 0, F, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, F, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, F, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, F, 0, 0, 0));
    // Set and clear together keeps pending; invalid mubi is not done
    vecs.push_back(mk(1, 0, 0, 0, T, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, Z, 1, 1, 0));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 0, 0, 0, Z, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, Z, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, F, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

    // Async reset in the middle of ShaWait
    step(mk(1, 0, 0, 0, F, 1, 0, 0), "ar_en");
    step(mk(0, 0, 0, 1, F, 1, 1, 0), "ar_drain");
    step(mk(0, 0, 0, 0, F, 0, 1, 0), "ar_shawait0");
    step(mk(0, 0, 0, 0, F, 0, 1, 0), "ar_shawait1");
    #2 rst_n = 1'b0;
    #1;
    chk("ar_enable_now", enable_o, 1'b0);
    chk("ar_busy_now", busy_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(mk(0, 0, 0, 0, F, 0, 0, 0), "ar_idle");
    step(mk(1, 0, 0, 0, F, 1, 0, 0), "ar_re_en");
    step(mk(0, 0, 0, 0, F, 1, 1, 0), "ar_re_drain");
    step(mk(0, 0, 0, 0, F, 0, 1, 0), "ar_re_hold");
    step(mk(0, 0, 0, 0, F, 0, 0, 0), "ar_re_idle");

    // Illegal state: recovers to Idle, fsm_err sticky
    force dut.state_q = state_e'(6'b111111);
    #1;
    chk("ill_enable", enable_o, 1'b0);
    chk("ill_busy", busy_o, 1'b0);
    chk("ill_ferr_before_edge", fsm_err_o, 1'b0);
    @(negedge clk);
    chk("ill_ferr_set", fsm_err_o, 1'b1);
    release dut.state_q;
    @(negedge clk);
    chk("ill_idle_enable", enable_o, 1'b0);
    chk("ill_idle_busy", busy_o, 1'b0);
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("ill_recover_en", enable_o, 1'b1);
    chk("ill_ferr_sticky", fsm_err_o, 1'b1);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("ill_final_busy", busy_o, 1'b0);
    chk("ill_ferr_sticky2", fsm_err_o, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
